// File: rtl/iterative_magnitude_comparator.sv
// Multi-cycle magnitude comparator: compares WIDTH-bit operands SLICE bits per clock,
// MSB slice first, stopping at the first differing slice; unsigned or two's-complement.
module iterative_magnitude_comparator #(
   parameter int WIDTH = 16,
   parameter int SLICE = 2,
   localparam int SLICES = WIDTH / SLICE,
   localparam int CW = $clog2(SLICES + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             signed_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             equal,
   output logic             less,
   output logic             greater,
   output logic [CW-1:0]    slices_used
);

   localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COMPARE = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   if (SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_bad_params
      $error("iterative_magnitude_comparator: WIDTH must be a positive multiple of SLICE");
   end

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             signed_q, signed_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             equal_q, equal_d, less_q, less_d, greater_q, greater_d;
   logic [CW-1:0]    su_q, su_d;

   logic [WIDTH-1:0] a_mod, b_mod;
   logic [SLICE-1:0] a_slice, b_slice;
   logic             capture;

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      signed_d  = signed_q;
      idx_d     = idx_q;
      equal_d   = equal_q;
      less_d    = less_q;
      greater_d = greater_q;
      su_d      = su_q;

      // Flipping both sign bits maps two's-complement order onto unsigned order.
      a_mod = a_q;
      b_mod = b_q;
      if (signed_q) begin
         a_mod[WIDTH-1] = ~a_q[WIDTH-1];
         b_mod[WIDTH-1] = ~b_q[WIDTH-1];
      end
      a_slice = a_mod[int'(idx_q) * SLICE +: SLICE];
      b_slice = b_mod[int'(idx_q) * SLICE +: SLICE];

      // DONE also accepts start so back-to-back requests capture on the edge done falls.
      capture = start && (state_q == IDLE || state_q == DONE);

      case (state_q)
         IDLE: ;
         COMPARE: begin
            if (a_slice != b_slice) begin
               equal_d   = 1'b0;
               less_d    = (a_slice < b_slice);
               greater_d = (a_slice > b_slice);
               su_d      = CW'(SLICES) - CW'(idx_q);
               state_d   = DONE;
            end else if (idx_q == '0) begin
               equal_d   = 1'b1;
               less_d    = 1'b0;
               greater_d = 1'b0;
               su_d      = CW'(SLICES);
               state_d   = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (capture) begin
         a_d      = a;
         b_d      = b;
         signed_d = signed_mode;
         idx_d    = IW'(SLICES - 1);
         state_d  = COMPARE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         signed_q  <= 1'b0;
         idx_q     <= '0;
         equal_q   <= 1'b0;
         less_q    <= 1'b0;
         greater_q <= 1'b0;
         su_q      <= '0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         signed_q  <= signed_d;
         idx_q     <= idx_d;
         equal_q   <= equal_d;
         less_q    <= less_d;
         greater_q <= greater_d;
         su_q      <= su_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign equal       = equal_q;
   assign less        = less_q;
   assign greater     = greater_q;
   assign slices_used = su_q;

endmodule

// File: tb/tb_iterative_magnitude_comparator.sv
// Scoreboard bench: stimulus pushes hand-computed results, negedge monitors pop on done.
module tb_iterative_magnitude_comparator;

   typedef struct {
      logic  eq;
      logic  lt;
      logic  gt;
      int    su;
      string nm;
   } exp_t;

   logic clk, rst_n;

   logic        start16, sm16, busy16, done16, eq16, lt16, gt16;
   logic [15:0] a16, b16;
   logic [3:0]  su16;

   logic        start8, sm8, busy8, done8, eq8, lt8, gt8;
   logic [7:0]  a8, b8;
   logic [0:0]  su8;

   exp_t q16[$];
   exp_t q8[$];
   int   tests = 0;
   int   fails = 0;
   int   cnt16 = 0, cnt8 = 0;
   bit   have16 = 0, have8 = 0;
   logic [6:0] last16;
   logic [3:0] last8;

   iterative_magnitude_comparator #(.WIDTH(16), .SLICE(2)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .equal(eq16), .less(lt16), .greater(gt16),
      .slices_used(su16)
   );

   iterative_magnitude_comparator #(.WIDTH(8), .SLICE(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .equal(eq8), .less(lt8), .greater(gt8),
      .slices_used(su8)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0d required %0d", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input logic eq, input logic lt, input logic gt,
                               input int su, input string nm);
      exp_t e;
      e.eq = eq; e.lt = lt; e.gt = gt; e.su = su; e.nm = nm;
      return e;
   endfunction

   // Monitors: latency is measured in busy negedges from capture to done (slices_used + 1).
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cnt16 = 0; have16 = 0;
      end else if (!busy16) begin
         cnt16 = 0;
      end else begin
         cnt16++;
         if (done16) begin
            if (q16.size() == 0) begin
               chk("unexpected_done16", 1, 0);
            end else begin
               e = q16.pop_front();
               chk({e.nm, "_equal"}, eq16, e.eq);
               chk({e.nm, "_less"}, lt16, e.lt);
               chk({e.nm, "_greater"}, gt16, e.gt);
               chk({e.nm, "_slices_used"}, su16, e.su);
               chk({e.nm, "_latency"}, cnt16, e.su + 1);
               chk({e.nm, "_onehot"}, int'(eq16) + int'(lt16) + int'(gt16), 1);
            end
            last16 = {eq16, lt16, gt16, su16};
            have16 = 1;
            cnt16  = 0;
         end else if (have16) begin
            chk("hold16", {eq16, lt16, gt16, su16}, last16);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cnt8 = 0; have8 = 0;
      end else if (!busy8) begin
         cnt8 = 0;
      end else begin
         cnt8++;
         if (done8) begin
            if (q8.size() == 0) begin
               chk("unexpected_done8", 1, 0);
            end else begin
               e = q8.pop_front();
               chk({e.nm, "_equal"}, eq8, e.eq);
               chk({e.nm, "_less"}, lt8, e.lt);
               chk({e.nm, "_greater"}, gt8, e.gt);
               chk({e.nm, "_slices_used"}, su8, e.su);
               chk({e.nm, "_latency"}, cnt8, e.su + 1);
            end
            last8 = {eq8, lt8, gt8, su8};
            have8 = 1;
            cnt8  = 0;
         end else if (have8) begin
            chk("hold8", {eq8, lt8, gt8, su8}, last8);
         end
      end
   end

   task automatic wait_idle16();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy16 && n < 40);
      if (busy16) chk("timeout16_idle", 1, 0);
   endtask

   task automatic wait_idle8();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy8 && n < 40);
      if (busy8) chk("timeout8_idle", 1, 0);
   endtask

   task automatic issue16(input logic [15:0] va, input logic [15:0] vb, input logic sm,
                          input logic eq, input logic lt, input logic gt, input int su,
                          input string nm);
      wait_idle16();
      a16 = va; b16 = vb; sm16 = sm; start16 = 1'b1;
      q16.push_back(mk(eq, lt, gt, su, nm));
      @(posedge clk);
      #1;
      start16 = 1'b0; a16 = ~va; b16 = 16'h5A5A; sm16 = ~sm;
      wait_idle16();
   endtask

   task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic sm,
                         input logic eq, input logic lt, input logic gt, input string nm);
      wait_idle8();
      a8 = va; b8 = vb; sm8 = sm; start8 = 1'b1;
      q8.push_back(mk(eq, lt, gt, 1, nm));
      @(posedge clk);
      #1;
      start8 = 1'b0; a8 = ~va; b8 = 8'hC3; sm8 = ~sm;
      wait_idle8();
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start16 = 1'b0; sm16 = 1'b0; a16 = '0; b16 = '0;
      start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
      @(negedge clk);
      chk("reset_busy", busy16, 0);
      chk("reset_done", done16, 0);
      chk("reset_results", {eq16, lt16, gt16, su16}, 0);
      chk("reset_results8", {busy8, done8, eq8, lt8, gt8, su8}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue16(16'hA5A5, 16'hA5A5, 0, 1, 0, 0, 8, "eq_a5a5");
      issue16(16'h8000, 16'h7FFF, 0, 0, 0, 1, 1, "u_8000_7fff");
      issue16(16'h8000, 16'h7FFF, 1, 0, 1, 0, 1, "s_8000_7fff");
      issue16(16'h1234, 16'h1235, 0, 0, 1, 0, 8, "u_1234_1235");
      issue16(16'hFFFF, 16'hFFFE, 1, 0, 0, 1, 8, "s_ffff_fffe");
      issue16(16'h0400, 16'h0800, 0, 0, 1, 0, 3, "u_0400_0800");
      issue16(16'hFF00, 16'h0001, 1, 0, 1, 0, 1, "s_ff00_0001");
      issue16(16'h8000, 16'h8000, 1, 1, 0, 0, 8, "s_eq_8000");

      // Back-to-back with start held high; operands scrambled while each op is in flight.
      wait_idle16();
      a16 = 16'h0001; b16 = '0; sm16 = 1'b0; start16 = 1'b1;
      q16.push_back(mk(0, 0, 1, 8, "b2b_0"));
      for (int i = 1; i < 4; i++) begin
         @(posedge clk);
         #1;
         a16 = 16'hFFFF; b16 = 16'h1234; sm16 = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!done16 && n < 40);
         if (!done16) chk("timeout_b2b_done", 1, 0);
         sm16 = 1'b0; b16 = '0;
         if (i % 2 == 1) begin
            a16 = 16'h0000;
            q16.push_back(mk(1, 0, 0, 8, $sformatf("b2b_%0d", i)));
         end else begin
            a16 = 16'h0001;
            q16.push_back(mk(0, 0, 1, 8, $sformatf("b2b_%0d", i)));
         end
      end
      @(posedge clk);
      #1;
      start16 = 1'b0; a16 = 16'hFFFF; b16 = 16'h1234;
      wait_idle16();

      // Reset during the 4th compare cycle of an equal compare: no done, outputs cleared.
      a16 = 16'h5555; b16 = 16'h5555; sm16 = 1'b0; start16 = 1'b1;
      @(posedge clk);
      #1;
      start16 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_busy", busy16, 0);
      chk("midreset_done", done16, 0);
      chk("midreset_results", {eq16, lt16, gt16, su16}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue16(16'h0003, 16'h0002, 0, 0, 0, 1, 8, "post_reset_3_2");

      issue8(8'h7F, 8'h80, 1, 0, 0, 1, "w8_s_7f_80");
      issue8(8'h7F, 8'h80, 0, 0, 1, 0, "w8_u_7f_80");
      issue8(8'h42, 8'h42, 1, 1, 0, 0, "w8_eq_42");

      repeat (4) @(negedge clk);
      chk("queue16_drained", q16.size(), 0);
      chk("queue8_drained", q8.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
